// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: two-flop synchroniser, receive FSM, small FIFO,
// and STATUS/DATA registers on the processor data bus.
module uart_rx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_rx,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_rd,
  input  logic        ip_data_wr,
  input  logic [31:0] ip_data_from_proc,
  output logic        op_data_valid,
  output logic [31:0] op_data_to_proc,
  output logic        op_rx_irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   DATA_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;

  logic          r_sync1, r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic          r_overrun, r_frame_err, r_irq;

  logic w_rx_s, w_expiry, w_push, w_ferr_set;
  logic w_empty, w_full, w_hit_status, w_hit_data, w_pop, w_push_ok, w_ovr_set;
  logic w_clr_ovr, w_clr_ferr;
  logic [31:0] w_status, w_head;
  logic w_unused;

  assign w_rx_s     = r_sync2;
  assign w_expiry   = (r_baud == '0);
  assign w_push     = (r_state == S_STOP) && w_expiry && w_rx_s;
  assign w_ferr_set = (r_state == S_STOP) && w_expiry && !w_rx_s;

  // Receive FSM; samples land at bit centres because START waits half a bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync1 <= ip_rx;
      r_sync2 <= r_sync1;
      case (r_state)
        S_IDLE: if (!w_rx_s) begin
          r_baud  <= HALF_BIT;
          r_state <= S_START;
        end
        S_START: if (w_expiry) begin
          if (!w_rx_s) begin
            r_state <= S_DATA;
            r_baud  <= FULL_BIT;
            r_bit   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end else r_baud <= r_baud - 1'b1;
        S_DATA: if (w_expiry) begin
          r_shift[r_bit] <= w_rx_s;
          r_baud         <= FULL_BIT;
          if (r_bit == 3'd7) r_state <= S_STOP;
          else               r_bit   <= r_bit + 1'b1;
        end else r_baud <= r_baud - 1'b1;
        S_STOP: if (w_expiry) r_state <= w_rx_s ? S_IDLE : S_WAIT_IDLE;
                else          r_baud  <= r_baud - 1'b1;
        S_WAIT_IDLE: if (w_rx_s) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_hit_status = (ip_data_addr[31:2] == BASE_ADDR[31:2]);
  assign w_hit_data   = (ip_data_addr[31:2] == DATA_ADDR[31:2]);
  assign w_pop        = ip_data_rd && w_hit_data && !w_empty && !reset;
  // A same-cycle pop frees the slot the incoming byte needs.
  assign w_push_ok    = w_push && (!w_full || w_pop);
  assign w_ovr_set    = w_push && w_full && !w_pop;
  assign w_clr_ovr    = ip_data_wr && w_hit_status && !reset && ip_data_from_proc[1];
  assign w_clr_ferr   = ip_data_wr && w_hit_status && !reset && ip_data_from_proc[2];

  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) r_mem[r_wptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_overrun   <= (r_overrun   && !w_clr_ovr)  || w_ovr_set;
      r_frame_err <= (r_frame_err && !w_clr_ferr) || w_ferr_set;
      r_irq       <= !w_empty;
    end
  end

  assign w_status = {28'd0, w_full, r_frame_err, r_overrun, !w_empty};
  assign w_head   = w_empty ? 32'd0 : {24'd0, r_mem[r_rptr[AW-1:0]]};

  assign op_data_valid   = ip_data_rd && (w_hit_status || w_hit_data) && !reset;
  assign op_data_to_proc = !op_data_valid ? 32'd0 : (w_hit_status ? w_status : w_head);
  assign op_rx_irq       = r_irq;

  assign w_unused = ^{ip_data_addr[1:0], ip_data_from_proc[31:3], ip_data_from_proc[0]};
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Randomised scoreboard bench for uart_rx_mmio: reads push expected data from a
// queue-based reference model; a negedge monitor pops and compares.
module tb_uart_rx_mmio;
  localparam int          C    = 4;
  localparam int          DEP  = 4;
  localparam logic [31:0] STAT = 32'h8000_0000;
  localparam logic [31:0] DATA = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        reset, ip_rx, ip_data_rd, ip_data_wr;
  logic [31:0] ip_data_addr, ip_data_from_proc, op_data_to_proc;
  logic        op_data_valid, op_rx_irq;

  uart_rx_mmio #(.BASE_ADDR(STAT), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .ip_rx(ip_rx),
    .ip_data_addr(ip_data_addr), .ip_data_rd(ip_data_rd), .ip_data_wr(ip_data_wr),
    .ip_data_from_proc(ip_data_from_proc),
    .op_data_valid(op_data_valid), .op_data_to_proc(op_data_to_proc), .op_rx_irq(op_rx_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: received bytes in arrival order plus the two sticky flags.
  byte unsigned m_q[$];
  bit           m_ovr = 1'b0, m_ferr = 1'b0;
  logic [31:0]  exp_q[$];
  logic         tb_hit = 1'b0;

  function automatic logic [31:0] m_status();
    return {28'd0, (m_q.size() == DEP), m_ferr, m_ovr, (m_q.size() != 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic [31:0] addr);
    logic hs, hd;
    hs = (addr[31:2] == STAT[31:2]) && !reset;
    hd = (addr[31:2] == DATA[31:2]) && !reset;
    if (hs) exp_q.push_back(m_status());
    else if (hd) exp_q.push_back((m_q.size() != 0) ? {24'd0, m_q.pop_front()} : 32'd0);
    tb_hit       = hs || hd;
    ip_data_addr = addr;
    ip_data_rd   = 1'b1;
    step();
    ip_data_rd = 1'b0;
    tb_hit     = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] d);
    if (addr[31:2] == STAT[31:2]) begin
      if (d[1]) m_ovr  = 1'b0;
      if (d[2]) m_ferr = 1'b0;
    end
    ip_data_addr      = addr;
    ip_data_from_proc = d;
    ip_data_wr        = 1'b1;
    step();
    ip_data_wr = 1'b0;
  endtask

  task automatic chk_irq(input string name);
    step();
    check(name, {31'd0, op_rx_irq}, {31'd0, (m_q.size() != 0)});
  endtask

  // Serialise one 8N1 frame; the stop level is held for stop_bits bit times.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
    ip_rx = 1'b0;
    repeat (C) step();
    for (int i = 0; i < 8; i++) begin
      ip_rx = b[i];
      repeat (C) step();
    end
    ip_rx = stop;
    repeat (C * stop_bits) step();
    ip_rx = 1'b1;
    repeat (C) step();
    if (!stop)                   m_ferr = 1'b1;
    else if (m_q.size() == DEP)  m_ovr  = 1'b1;
    else                         m_q.push_back(b);
  endtask

  // Monitor: every cycle the DUT drives or is asked for read data gets compared.
  always @(negedge clk) begin
    if (ip_data_rd || op_data_valid) begin
      check("rd_valid", {31'd0, op_data_valid}, {31'd0, tb_hit});
      if (op_data_valid && tb_hit) begin
        if (exp_q.size() == 0) check("rd_unexpected", op_data_to_proc, 32'hxxxx_xxxx);
        else                   check("rd_data", op_data_to_proc, exp_q.pop_front());
      end else begin
        check("rd_idle_zero", op_data_to_proc, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; ip_rx = 1'b1; ip_data_rd = 1'b0; ip_data_wr = 1'b0;
    ip_data_addr = '0; ip_data_from_proc = '0;
    repeat (3) step();
    check("reset_irq", {31'd0, op_rx_irq}, 32'd0);
    bus_rd(STAT);
    reset = 1'b0;
    step();
    bus_rd(STAT);

    // 1: single byte round trip
    send_frame(8'h41, 1'b1, 1);
    check("s1_irq_up", {31'd0, op_rx_irq}, 32'd1);
    bus_rd(STAT);
    bus_rd(DATA);
    chk_irq("s1_irq_fall");
    bus_rd(STAT);

    // 2: overrun on the fifth byte, drain, underflow read, W1C
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, 1);
    bus_rd(STAT);
    check("s2_status_model", m_status(), 32'hB);
    for (int i = 0; i < 5; i++) bus_rd(DATA);
    bus_rd(STAT);
    bus_wr(STAT, 32'h2);
    bus_rd(STAT);

    // 3: framing error with a held break, then a good byte
    send_frame(8'hFF, 1'b0, 3);
    bus_rd(STAT);
    send_frame(8'h5A, 1'b1, 1);
    bus_rd(STAT);
    bus_rd(DATA);

    // 4: one-cycle glitch must be rejected
    ip_rx = 1'b0;
    step();
    ip_rx = 1'b1;
    repeat (10) step();
    bus_rd(STAT);
    chk_irq("s4_irq");

    // 5: pop lands on the same edge as the stop-bit push of a full FIFO
    for (int i = 0; i < DEP; i++) send_frame(8'hA0 + 8'(i), 1'b1, 1);
    fork
      send_frame(8'h77, 1'b1, 1);
      begin
        repeat (4 + 9 * C) step();
        bus_rd(DATA);
      end
    join
    bus_rd(STAT);
    for (int i = 0; i < DEP; i++) bus_rd(DATA);
    bus_rd(STAT);

    // 6: reset during data bit 3, then a clean frame
    send_frame(8'h99, 1'b1, 1);
    ip_rx = 1'b0;
    repeat (C) step();
    for (int i = 0; i < 3; i++) begin
      ip_rx = (8'hC3 >> i) & 8'h1;
      repeat (C) step();
    end
    ip_rx = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ip_rx = 1'b1;
    m_q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    check("s6_irq_after_reset", {31'd0, op_rx_irq}, 32'd0);
    repeat (12 * C) step();
    bus_rd(STAT);
    send_frame(8'hC3, 1'b1, 1);
    bus_rd(STAT);
    bus_rd(DATA);

    // Randomised mix of frames, reads, writes and unmapped accesses
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 1);
        4, 5, 6:    bus_rd(DATA | 32'($urandom_range(0, 3)));
        7:          bus_rd(STAT | 32'($urandom_range(0, 3)));
        8:          bus_wr(($urandom_range(0, 1) != 0) ? STAT : DATA, $urandom);
        default:    bus_rd(($urandom_range(0, 1) != 0) ? 32'h8000_0010 : 32'h0000_0004);
      endcase
      if (n % 10 == 9) chk_irq("rand_irq");
    end
    for (int i = 0; i < DEP + 1; i++) bus_rd(DATA);
    bus_rd(STAT);
    chk_irq("final_irq");
    repeat (2) step();

    if (exp_q.size() != 0) check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
